cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_fifo.sv | 72 +++++++
 rtl/cdb_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared widths and source identifiers for the common-data-bus arbiter.
//   TAG_W, DATA_W : default ROB tag and result widths
//   ADDR_W        : width of a branch redirect target
//   SRC_*         : source IDs as broadcast on cdb_src
//   next_src()    : round-robin successor of a source ID (wraps 2 -> 0)
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_LSB = 2'd1;
    localparam logic [1:0] SRC_BR  = 2'd2;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_BR) ? SRC_ALU : s + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Small synchronous FIFO holding results for one CDB source.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous empty (pipeline clear); drops a same-cycle push
//   push       : write push_data (caller guarantees !full)
//   pop        : advance head (caller guarantees !empty)
//   head       : oldest entry
//   empty/full : registered occupancy flags
// -----------------------------------------------------------------------------
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && !rst && !flush;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (pop)     rd_ptr <= bump(rd_ptr);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count and
    // pointers, so stale words are never observed and need no clearing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Collects results from ALU, load/store and branch units into per-source FIFOs
// and broadcasts one per cycle on the common data bus, round-robin.
//   clk, rst             : clock, synchronous active-high reset
//   rdy                  : global enable; low freezes queues and arbitration
//   clear                : pipeline flush; empties all queues
//   alu_* / lsb_* / br_* : valid/ready result inputs per source
//   cdb_*                : registered broadcast (valid, source, tag, data,
//                          jump and pc; jump/pc are zero unless source is branch)
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int TAG_W      = cdb_arbiter_pkg::TAG_W,
    parameter int DATA_W     = cdb_arbiter_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_data,
    output logic              lsb_ready,
    input  logic              br_valid,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic [DATA_W-1:0] br_data,
    input  logic              br_jump,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              br_ready,
    output logic              cdb_valid,
    output logic [1:0]        cdb_src,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_jump,
    output logic [ADDR_W-1:0] cdb_pc
);

    localparam int RES_W = TAG_W + DATA_W;
    localparam int BR_W  = DATA_W + TAG_W + 1 + ADDR_W;

    logic [2:0]       empty;
    logic [2:0]       full;
    logic [2:0]       pop;
    logic [RES_W-1:0] alu_head;
    logic [RES_W-1:0] lsb_head;
    logic [BR_W-1:0]  br_head;
    logic             accept_ok;
    logic             flush;
    logic [1:0]       last_grant;
    logic [1:0]       winner;
    logic             found;
    logic             pop_en;

    // Readiness depends only on registered occupancy and the global controls,
    // never on the valids; a full queue stays not-ready even while popping.
    assign accept_ok = rdy && !clear && !rst;
    assign alu_ready = accept_ok && !full[SRC_ALU];
    assign lsb_ready = accept_ok && !full[SRC_LSB];
    assign br_ready  = accept_ok && !full[SRC_BR];
    assign flush     = clear && rdy;

    cdb_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (alu_valid && alu_ready),
        .push_data ({alu_tag, alu_data}),
        .pop       (pop[SRC_ALU]),
        .head      (alu_head),
        .empty     (empty[SRC_ALU]),
        .full      (full[SRC_ALU])
    );

    cdb_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (lsb_valid && lsb_ready),
        .push_data ({lsb_tag, lsb_data}),
        .pop       (pop[SRC_LSB]),
        .head      (lsb_head),
        .empty     (empty[SRC_LSB]),
        .full      (full[SRC_LSB])
    );

    cdb_fifo #(.WIDTH(BR_W), .DEPTH(FIFO_DEPTH)) u_br_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (br_valid && br_ready),
        .push_data ({br_jump, br_pc, br_tag, br_data}),
        .pop       (pop[SRC_BR]),
        .head      (br_head),
        .empty     (empty[SRC_BR]),
        .full      (full[SRC_BR])
    );

    // Round-robin search starting just after the last granted source. Only
    // registered emptiness is consulted, so a result pushed this cycle cannot
    // be popped until the next one.
    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin : rr_search
        logic [1:0] cand;
        winner = last_grant;
        found  = 1'b0;
        cand   = next_src(last_grant);
        for (int k = 0; k < 3; k++) begin
            if (!found && !empty[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = next_src(cand);
        end
    end

    assign pop_en       = found && rdy && !clear && !rst;
    assign pop[SRC_ALU] = pop_en && (winner == SRC_ALU);
    assign pop[SRC_LSB] = pop_en && (winner == SRC_LSB);
    assign pop[SRC_BR]  = pop_en && (winner == SRC_BR);

    // Broadcast register: the popped head appears the cycle after the pop;
    // any cycle without a pop drives an all-zero bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_src    <= '0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_jump   <= 1'b0;
            cdb_pc     <= '0;
            last_grant <= SRC_BR;
        end else begin
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_jump  <= 1'b0;
            cdb_pc    <= '0;
            if (pop_en) begin
                cdb_valid  <= 1'b1;
                cdb_src    <= winner;
                last_grant <= winner;
                case (winner)
                    SRC_ALU: {cdb_tag, cdb_data} <= alu_head;
                    SRC_LSB: {cdb_tag, cdb_data} <= lsb_head;
                    default: {cdb_jump, cdb_pc, cdb_tag, cdb_data} <= br_head;
                endcase
            end
        end
    end

endmodule
